// File: rtl/board_gpio_conditioner_pkg.sv
// Shared types and bit-mapping helpers for the board GPIO conditioner.
// Maps button/LED channel indices onto the flat SoC GPIO and duty buses.
package board_io_pkg;

  localparam int BtnLevelOffset = 0;
  localparam int PwmMaxBits     = 16;

  // Wide enough for any supported PwmBits; the live counter is masked down.
  typedef logic [PwmMaxBits-1:0] pwm_cnt_t;

  function automatic int btn_level_bit(input int k);
    return BtnLevelOffset + k;
  endfunction

  // Sticky press flags sit directly above the NumBtn level bits.
  function automatic int btn_event_bit(input int k, input int num_btn);
    return num_btn + k;
  endfunction

  function automatic int duty_slice(input int k, input int pwm_bits);
    return k * pwm_bits;
  endfunction

endpackage

// File: rtl/board_gpio_conditioner_if.sv
// SoC-facing GPIO bus of the conditioner: gpio_i/gpio_o words, LED duties, flag clears.
// No valid/ready handshake: levels are sampled every cycle, evt_clr_i bits are one-cycle pulses.
interface board_gpio_conditioner_if #(
  parameter int NumBtn    = 3,
  parameter int NumLed    = 5,
  parameter int GpioWidth = 32,
  parameter int PwmBits   = 4
);
  logic [GpioWidth-1:0]      soc_gpio_i_o;
  logic [GpioWidth-1:0]      soc_gpio_o_i;
  logic [NumLed*PwmBits-1:0] led_duty_i;
  logic [NumBtn-1:0]         evt_clr_i;

  modport master (
    input  soc_gpio_i_o,
    output soc_gpio_o_i,
    output led_duty_i,
    output evt_clr_i
  );

  modport slave (
    output soc_gpio_i_o,
    input  soc_gpio_o_i,
    input  led_duty_i,
    input  evt_clr_i
  );
endinterface

// File: rtl/board_gpio_conditioner_debounce.sv
// Single-channel button path: N-stage synchroniser, persistence counter, stable level.
// rise_o is high on the cycle the stable level is about to go 0->1.
module gpio_debounce #(
  parameter int SyncStages     = 2,
  parameter int DebounceCycles = 60000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o
);
  localparam int CntW = $clog2(DebounceCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic [SyncStages-1:0] sync_q;
  logic [CntW-1:0]       cnt_q;
  logic                  stable_q;
  logic                  synced;
  logic                  expired;

  assign synced  = sync_q[SyncStages-1];
  assign expired = (synced != stable_q) && (cnt_q == CntMax);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], pin_i};
      // Any return to the stable level drops the partial count.
      if (synced == stable_q) begin
        cnt_q <= '0;
      end else if (expired) begin
        stable_q <= synced;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign level_o = stable_q;
  assign rise_o  = expired & synced;

endmodule

// File: rtl/board_gpio_conditioner.sv
// Board pin conditioner: debounced buttons with sticky press flags towards the SoC,
// and per-LED gated PWM dimmers driven from SoC gpio_o enables.
module board_gpio_conditioner
  import board_io_pkg::*;
#(
  parameter int               NumBtn         = 3,
  parameter int               NumLed         = 5,
  parameter int               GpioWidth      = 32,
  parameter int               SyncStages     = 2,
  parameter int               DebounceCycles = 60000,
  parameter logic [NumBtn-1:0] BtnInvert     = '0,
  parameter int               PwmBits        = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumBtn-1:0]           btn_pin_i,
  output logic [NumLed-1:0]           led_pin_o,
  board_gpio_conditioner_if.slave     bus
);
  localparam pwm_cnt_t PwmMask = pwm_cnt_t'((1 << PwmBits) - 1);

  if (2 * NumBtn > GpioWidth) begin : g_chk_btn
    $fatal(1, "board_gpio_conditioner: 2*NumBtn exceeds GpioWidth");
  end
  if (NumLed > GpioWidth) begin : g_chk_led
    $fatal(1, "board_gpio_conditioner: NumLed exceeds GpioWidth");
  end
  if (SyncStages < 2) begin : g_chk_sync
    $fatal(1, "board_gpio_conditioner: SyncStages must be at least 2");
  end
  if (DebounceCycles < 2) begin : g_chk_deb
    $fatal(1, "board_gpio_conditioner: DebounceCycles must be at least 2");
  end
  if (PwmBits < 1 || PwmBits > PwmMaxBits) begin : g_chk_pwm
    $fatal(1, "board_gpio_conditioner: PwmBits out of range");
  end

  logic [NumBtn-1:0] level;
  logic [NumBtn-1:0] rise;
  logic [NumBtn-1:0] flag_q;
  pwm_cnt_t          cnt_q;
  logic [NumLed-1:0] led_d;
  logic [NumLed-1:0] led_q;

  for (genvar k = 0; k < NumBtn; k++) begin : g_btn
    gpio_debounce #(
      .SyncStages     (SyncStages),
      .DebounceCycles (DebounceCycles)
    ) u_debounce (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .pin_i   (btn_pin_i[k] ^ BtnInvert[k]),
      .level_o (level[k]),
      .rise_o  (rise[k])
    );
  end

  for (genvar k = 0; k < NumLed; k++) begin : g_led
    pwm_cnt_t duty;
    assign duty     = pwm_cnt_t'(bus.led_duty_i[duty_slice(k, PwmBits) +: PwmBits]);
    assign led_d[k] = bus.soc_gpio_o_i[k] & ((duty == PwmMask) || (cnt_q < duty));
  end

  if (NumLed < GpioWidth) begin : g_unused
    logic unused_gpio_o;
    assign unused_gpio_o = ^bus.soc_gpio_o_i[GpioWidth-1:NumLed];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flag_q <= '0;
      cnt_q  <= '0;
      led_q  <= '0;
    end else begin
      // Set wins over a same-cycle clear.
      flag_q <= rise | (flag_q & ~bus.evt_clr_i);
      cnt_q  <= (cnt_q + pwm_cnt_t'(1)) & PwmMask;
      led_q  <= led_d;
    end
  end

  always_comb begin
    bus.soc_gpio_i_o = '0;
    for (int k = 0; k < NumBtn; k++) begin
      bus.soc_gpio_i_o[btn_level_bit(k)]         = level[k];
      bus.soc_gpio_i_o[btn_event_bit(k, NumBtn)] = flag_q[k];
    end
  end

  assign led_pin_o = led_q;

endmodule

// File: tb/tb_board_gpio_conditioner.sv
// Directed self-checking bench for board_gpio_conditioner (DebounceCycles=4, SyncStages=2).
// A second instance with button 0 inverted covers the active-low input polarity.
module tb_board_gpio_conditioner;
  localparam int NumBtn = 3;
  localparam int NumLed = 5;
  localparam int GpioW  = 32;
  localparam int PwmB   = 4;

  logic clk;
  logic rst;
  logic [NumBtn-1:0] btn_pin;
  logic [NumBtn-1:0] btn_pin_inv;
  logic [NumLed-1:0] led_pin;
  logic [NumLed-1:0] led_pin_inv;

  int n_cmp = 0;
  int n_err = 0;

  board_gpio_conditioner_if #(.NumBtn(NumBtn), .NumLed(NumLed), .GpioWidth(GpioW), .PwmBits(PwmB)) bus ();
  board_gpio_conditioner_if #(.NumBtn(NumBtn), .NumLed(NumLed), .GpioWidth(GpioW), .PwmBits(PwmB)) bus_inv ();

  board_gpio_conditioner #(
    .NumBtn(NumBtn), .NumLed(NumLed), .GpioWidth(GpioW), .SyncStages(2),
    .DebounceCycles(4), .BtnInvert(3'b000), .PwmBits(PwmB)
  ) dut (
    .clk_i(clk), .rst_i(rst), .btn_pin_i(btn_pin), .led_pin_o(led_pin), .bus(bus)
  );

  board_gpio_conditioner #(
    .NumBtn(NumBtn), .NumLed(NumLed), .GpioWidth(GpioW), .SyncStages(2),
    .DebounceCycles(4), .BtnInvert(3'b001), .PwmBits(PwmB)
  ) dut_inv (
    .clk_i(clk), .rst_i(rst), .btn_pin_i(btn_pin_inv), .led_pin_o(led_pin_inv), .bus(bus_inv)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_pin = '0;
    btn_pin_inv = '0;
    bus.soc_gpio_o_i = '1;
    bus.led_duty_i = '1;
    bus.evt_clr_i = '0;
    bus_inv.soc_gpio_o_i = '0;
    bus_inv.led_duty_i = '0;
    bus_inv.evt_clr_i = '0;
    step(3);
    n_cmp++;
    if (bus.soc_gpio_i_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset_gpio: got %h expected %h", bus.soc_gpio_i_o, 32'h0);
    end
    n_cmp++;
    if (led_pin !== 5'b0) begin
      n_err++;
      $display("FAIL reset_led: got %b expected %b", led_pin, 5'b0);
    end
    bus.soc_gpio_o_i = '0;
    bus.led_duty_i = '0;
    rst = 1'b0;
    // inverted button 0 with pin low reads as pressed after 2+4 cycles
    for (int i = 1; i <= 6; i++) begin
      step(1);
      n_cmp++;
      if (bus_inv.soc_gpio_i_o !== ((i == 6) ? 32'h9 : 32'h0)) begin
        n_err++;
        $display("FAIL polarity cyc%0d: got %h expected %h", i, bus_inv.soc_gpio_i_o,
                 (i == 6) ? 32'h9 : 32'h0);
      end
      n_cmp++;
      if (bus.soc_gpio_i_o !== 32'h0) begin
        n_err++;
        $display("FAIL idle_after_reset cyc%0d: got %h expected %h", i, bus.soc_gpio_i_o, 32'h0);
      end
    end
  endtask

  task automatic test_clean_press();
    btn_pin[0] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      n_cmp++;
      if (bus.soc_gpio_i_o !== ((i == 6) ? 32'h9 : 32'h0)) begin
        n_err++;
        $display("FAIL clean_press cyc%0d: got %h expected %h", i, bus.soc_gpio_i_o,
                 (i == 6) ? 32'h9 : 32'h0);
      end
    end
    btn_pin[0] = 1'b0;
    step(8);
    n_cmp++;
    if (bus.soc_gpio_i_o !== 32'h8) begin
      n_err++;
      $display("FAIL release_keeps_flag: got %h expected %h", bus.soc_gpio_i_o, 32'h8);
    end
  endtask

  task automatic test_glitch();
    btn_pin[1] = 1'b1;
    step(3);
    btn_pin[1] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      n_cmp++;
      if (bus.soc_gpio_i_o !== 32'h8) begin
        n_err++;
        $display("FAIL glitch cyc%0d: got %h expected %h", i, bus.soc_gpio_i_o, 32'h8);
      end
    end
    btn_pin[1] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      n_cmp++;
      if (bus.soc_gpio_i_o !== ((i == 6) ? 32'h1A : 32'h8)) begin
        n_err++;
        $display("FAIL long_press cyc%0d: got %h expected %h", i, bus.soc_gpio_i_o,
                 (i == 6) ? 32'h1A : 32'h8);
      end
    end
  endtask

  task automatic test_sticky_clear();
    btn_pin[2] = 1'b1;
    step(6);
    n_cmp++;
    if (bus.soc_gpio_i_o !== 32'h3E) begin
      n_err++;
      $display("FAIL press2: got %h expected %h", bus.soc_gpio_i_o, 32'h3E);
    end
    bus.evt_clr_i = 3'b100;
    step(1);
    bus.evt_clr_i = 3'b000;
    n_cmp++;
    if (bus.soc_gpio_i_o !== 32'h1E) begin
      n_err++;
      $display("FAIL clear2: got %h expected %h", bus.soc_gpio_i_o, 32'h1E);
    end
    btn_pin[2] = 1'b0;
    step(8);
    btn_pin[2] = 1'b1;
    step(5);
    n_cmp++;
    if (bus.soc_gpio_i_o !== 32'h1A) begin
      n_err++;
      $display("FAIL pre_race: got %h expected %h", bus.soc_gpio_i_o, 32'h1A);
    end
    bus.evt_clr_i = 3'b100;
    step(1);
    bus.evt_clr_i = 3'b000;
    n_cmp++;
    if (bus.soc_gpio_i_o !== 32'h3E) begin
      n_err++;
      $display("FAIL set_wins: got %h expected %h", bus.soc_gpio_i_o, 32'h3E);
    end
    bus.evt_clr_i = 3'b011;
    step(1);
    bus.evt_clr_i = 3'b000;
    n_cmp++;
    if (bus.soc_gpio_i_o !== 32'h26) begin
      n_err++;
      $display("FAIL clear01: got %h expected %h", bus.soc_gpio_i_o, 32'h26);
    end
  endtask

  task automatic test_pwm();
    int hi [NumLed];
    int exp_a [NumLed] = '{5, 0, 16, 0, 8};
    int exp_b [NumLed] = '{16, 0, 16, 0, 1};
    // LED3 disabled while at full duty; upper gpio_o bits must be ignored
    bus.soc_gpio_o_i = 32'hFFFF_FFF7;
    bus.led_duty_i = {4'd8, 4'd15, 4'd15, 4'd0, 4'd5};
    step(2);
    for (int k = 0; k < NumLed; k++) hi[k] = 0;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < NumLed; k++) hi[k] += int'(led_pin[k]);
      step(1);
    end
    for (int k = 0; k < NumLed; k++) begin
      n_cmp++;
      if (hi[k] !== exp_a[k]) begin
        n_err++;
        $display("FAIL pwm_a led%0d: got %0d high expected %0d", k, hi[k], exp_a[k]);
      end
    end
    bus.led_duty_i = {4'd1, 4'd15, 4'd15, 4'd0, 4'd15};
    step(2);
    for (int k = 0; k < NumLed; k++) hi[k] = 0;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < NumLed; k++) hi[k] += int'(led_pin[k]);
      step(1);
    end
    for (int k = 0; k < NumLed; k++) begin
      n_cmp++;
      if (hi[k] !== exp_b[k]) begin
        n_err++;
        $display("FAIL pwm_b led%0d: got %0d high expected %0d", k, hi[k], exp_b[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.soc_gpio_o_i = 32'h1;
    bus.led_duty_i = {4'd0, 4'd0, 4'd0, 4'd0, 4'd15};
    step(2);
    n_cmp++;
    if (led_pin !== 5'b00001) begin
      n_err++;
      $display("FAIL led_on_before_rst: got %b expected %b", led_pin, 5'b00001);
    end
    btn_pin[0] = 1'b1;
    step(4);
    rst = 1'b1;
    step(1);
    n_cmp++;
    if (bus.soc_gpio_i_o !== 32'h0) begin
      n_err++;
      $display("FAIL midrst_gpio: got %h expected %h", bus.soc_gpio_i_o, 32'h0);
    end
    n_cmp++;
    if (led_pin !== 5'b0) begin
      n_err++;
      $display("FAIL midrst_led: got %b expected %b", led_pin, 5'b0);
    end
    n_cmp++;
    if (bus_inv.soc_gpio_i_o !== 32'h0) begin
      n_err++;
      $display("FAIL midrst_inv: got %h expected %h", bus_inv.soc_gpio_i_o, 32'h0);
    end
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      n_cmp++;
      if (bus.soc_gpio_i_o !== ((i == 6) ? 32'h3F : 32'h0)) begin
        n_err++;
        $display("FAIL post_rst_press cyc%0d: got %h expected %h", i, bus.soc_gpio_i_o,
                 (i == 6) ? 32'h3F : 32'h0);
      end
      n_cmp++;
      if (bus_inv.soc_gpio_i_o !== ((i == 6) ? 32'h9 : 32'h0)) begin
        n_err++;
        $display("FAIL post_rst_inv cyc%0d: got %h expected %h", i, bus_inv.soc_gpio_i_o,
                 (i == 6) ? 32'h9 : 32'h0);
      end
      if (i == 1) begin
        n_cmp++;
        if (led_pin !== 5'b00001) begin
          n_err++;
          $display("FAIL post_rst_led: got %b expected %b", led_pin, 5'b00001);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_sticky_clear();
    test_pwm();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
